// File: rtl/fpu_op_issue.sv
// ---------------------------------------------------------------------------
// fpu_op_issue
//
// Issue/capture stage wrapped around a combinational float32 add/sub ALU.
// Requests are buffered in a small FIFO, operands are registered into the
// ALU, and IEEE special cases the ALU cannot handle (zero, denormal, Inf,
// NaN, exact cancellation) are resolved by bypass. The final result is
// registered behind a valid/ready output handshake.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst_n          synchronous active-low reset
//   in_valid/in_ready/in_op/in_a/in_b   request channel (op: 0 = A+B, 1 = A-B)
//   alu_operation/alu_opa/alu_opb       registered operands driven to the ALU
//   alu_result     combinational ALU result, sampled in EXEC
//   out_valid/out_ready/out_result      result channel
//   out_flags      {invalid, overflow, zero, bypass}, valid while out_valid=1
// ---------------------------------------------------------------------------
module fpu_op_issue #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] QNAN       = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        alu_operation,
  output logic [31:0] alu_opa,
  output logic [31:0] alu_opb,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  // -------------------------------------------------------------------------
  // Request FIFO: entry = {op, a, b}
  // -------------------------------------------------------------------------
  logic [64:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [64:0]     w_head;

  assign w_full   = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // A full FIFO never accepts, even if the FSM pops in the same cycle.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_op, in_a, in_b};
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand classification and bypass precompute on the FIFO head
  // -------------------------------------------------------------------------
  logic        w_h_op;
  logic [31:0] w_h_a;
  logic [31:0] w_h_b;
  logic        w_sa;
  logic        w_sb;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_inf;
  logic        w_b_inf;
  logic        w_a_nan;
  logic        w_b_nan;

  assign w_h_op   = w_head[64];
  assign w_h_a    = w_head[63:32];
  assign w_h_b    = w_head[31:0];
  assign w_sa     = w_h_a[31];
  // Subtraction is addition with B's sign flipped.
  assign w_sb     = w_h_b[31] ^ w_h_op;
  // Exponent 0 covers denormals too: they are flushed to signed zero.
  assign w_a_zero = (w_h_a[30:23] == 8'h00);
  assign w_b_zero = (w_h_b[30:23] == 8'h00);
  assign w_a_inf  = (w_h_a[30:23] == 8'hFF) && (w_h_a[22:0] == '0);
  assign w_b_inf  = (w_h_b[30:23] == 8'hFF) && (w_h_b[22:0] == '0);
  assign w_a_nan  = (w_h_a[30:23] == 8'hFF) && (w_h_a[22:0] != '0);
  assign w_b_nan  = (w_h_b[30:23] == 8'hFF) && (w_h_b[22:0] != '0);

  logic        w_byp_en;
  logic [31:0] w_byp_res;
  logic [3:0]  w_byp_flags;

  // Priority chain; the first matching rule wins.
  always_comb begin
    w_byp_en    = 1'b1;
    w_byp_res   = '0;
    w_byp_flags = 4'b0001;
    if (w_a_nan || w_b_nan) begin
      w_byp_res   = QNAN;
      w_byp_flags = 4'b1001;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_byp_res   = QNAN;
      w_byp_flags = 4'b1001;
    end else if (w_a_inf) begin
      w_byp_res   = {w_sa, w_h_a[30:0]};
    end else if (w_b_inf) begin
      w_byp_res   = {w_sb, w_h_b[30:0]};
    end else if (w_a_zero && w_b_zero) begin
      w_byp_res   = {w_sa && w_sb, 31'h0};
      w_byp_flags = 4'b0011;
    end else if (w_a_zero) begin
      w_byp_res   = {w_sb, w_h_b[30:0]};
    end else if (w_b_zero) begin
      w_byp_res   = w_h_a;
    end else if ((w_sa != w_sb) && (w_h_a[30:0] == w_h_b[30:0])) begin
      w_byp_res   = 32'h0;
      w_byp_flags = 4'b0011;
    end else begin
      w_byp_en    = 1'b0;
      w_byp_flags = 4'b0000;
    end
  end

  // -------------------------------------------------------------------------
  // ALU result post-processing
  // -------------------------------------------------------------------------
  logic        w_alu_ovf;
  logic        w_alu_zero;
  logic [31:0] w_alu_res;
  logic [3:0]  w_alu_flags;

  assign w_alu_ovf   = (alu_result[30:23] == 8'hFF);
  assign w_alu_zero  = (alu_result[30:0] == '0);
  // Exponent saturation is reported as a clean signed infinity.
  assign w_alu_res   = w_alu_ovf ? {alu_result[31], 8'hFF, 23'h0} : alu_result;
  assign w_alu_flags = {1'b0, w_alu_ovf, w_alu_zero, 1'b0};

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_e r_state;
  state_e w_state_next;
  logic   w_capture;
  logic   w_out_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) w_state_next = StExec;
      end
      StExec: begin
        w_state_next = StDone;
      end
      StDone: begin
        if (out_ready) w_state_next = w_empty ? StIdle : StExec;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_out_clr = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_pop = !w_empty;
      end
      StExec: begin
        w_capture = 1'b1;
      end
      StDone: begin
        w_out_clr = out_ready;
        w_pop     = out_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic        r_alu_op;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_byp_en;
  logic [31:0] r_byp_res;
  logic [3:0]  r_byp_flags;
  logic        r_out_valid;
  logic [31:0] r_out_result;
  logic [3:0]  r_out_flags;

  // Operands and bypass info load together on pop and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_op    <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_byp_en    <= 1'b0;
      r_byp_res   <= '0;
      r_byp_flags <= '0;
    end else if (w_pop) begin
      r_alu_op    <= w_h_op;
      r_alu_a     <= w_h_a;
      r_alu_b     <= w_h_b;
      r_byp_en    <= w_byp_en;
      r_byp_res   <= w_byp_res;
      r_byp_flags <= w_byp_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= r_byp_en ? r_byp_res : w_alu_res;
      r_out_flags  <= r_byp_en ? r_byp_flags : w_alu_flags;
    end else if (w_out_clr) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign alu_operation = r_alu_op;
  assign alu_opa       = r_alu_a;
  assign alu_opb       = r_alu_b;
  assign out_valid     = r_out_valid;
  assign out_result    = r_out_result;
  assign out_flags     = r_out_flags;

endmodule

// File: tb/tb_fpu_op_issue.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_issue
//
// Self-checking bench for fpu_op_issue. A behavioural ALU stand-in drives
// alu_result; every accepted request pushes its expected result onto a
// scoreboard queue which a monitor pops on each output handshake.
// ---------------------------------------------------------------------------
module tb_fpu_op_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        alu_operation;
  logic [31:0] alu_opa;
  logic [31:0] alu_opb;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fpu_op_issue #(
    .FIFO_DEPTH (2),
    .QNAN       (32'h7FC00000)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .alu_operation (alu_operation),
    .alu_opa       (alu_opa),
    .alu_opb       (alu_opb),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: a few exact answers, otherwise a deterministic value with a
  // normal, non-saturated exponent.
  function automatic logic [31:0] alu_f(input logic op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (!op && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
    if (!op && a == 32'h7F000000 && b == 32'h7F000000) return 32'h7F800123;
    if (op && a == 32'h3F800000 && b == 32'h3F800001) return 32'h00000000;
    return {a[31] ^ op, 8'h41, a[22:0] ^ b[22:0]};
  endfunction

  always_comb alu_result = alu_f(alu_operation, alu_opa, alu_opb);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] flg);
    exp_t e;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n        = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("accept", 32'(in_ready), 32'd1);
    e.op  = op;
    e.a   = a;
    e.b   = b;
    e.res = res;
    e.flg = flg;
    if (in_ready) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_alu(input logic op, input logic [31:0] a, input logic [31:0] b);
    send(op, a, b, alu_f(op, a, b), 4'b0000);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 32'(q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard compare on handshake, stability while stalled.
  initial begin
    logic        prev_v;
    logic        prev_rdy;
    logic [31:0] prev_res;
    logic [3:0]  prev_flg;
    exp_t        e;
    prev_v = 1'b0;
    prev_rdy = 1'b1;
    prev_res = '0;
    prev_flg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_rdy) begin
          check_val("hold_valid", 32'(out_valid), 32'd1);
          check_val("hold_result", out_result, prev_res);
          check_val("hold_flags", 32'(out_flags), 32'(prev_flg));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check_val("stale_out", 32'(out_valid), 32'd0);
          end else begin
            e = q.pop_front();
            check_val("result", out_result, e.res);
            check_val("flags", 32'(out_flags), 32'(e.flg));
            check_val("alu_opa", alu_opa, e.a);
            check_val("alu_opb", alu_opb, e.b);
            check_val("alu_op", 32'(alu_operation), 32'(e.op));
          end
        end
        prev_v   = out_valid;
        prev_rdy = out_ready;
        prev_res = out_result;
        prev_flg = out_flags;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t[$];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_result", out_result, 32'd0);
    check_val("rst_out_flags", 32'(out_flags), 32'd0);
    check_val("rst_alu_op", 32'(alu_operation), 32'd0);
    check_val("rst_alu_opa", alu_opa, 32'd0);
    check_val("rst_alu_opb", alu_opb, 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Latency: accept edge, load edge, capture edge.
    send(1'b0, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0000);
    @(negedge clk);
    check_val("lat_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_e2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_e3", 32'(out_valid), 32'd1);
    wait_drain();

    // Special cases and ALU path.
    send(1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1001);
    send(1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1001);
    send(1'b0, 32'h3F800000, 32'hFF800001, 32'h7FC00000, 4'b1001);
    send(1'b0, 32'hFF800000, 32'h7F800000, 32'h7FC00000, 4'b1001);
    send(1'b0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0001);
    send(1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0001);
    send(1'b1, 32'h40400000, 32'h40400000, 32'h00000000, 4'b0011);
    send(1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0011);
    send(1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 4'b0011);
    send(1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0011);
    send(1'b1, 32'h00000000, 32'h40000000, 32'hC0000000, 4'b0001);
    send(1'b0, 32'h00400000, 32'hC0000000, 32'hC0000000, 4'b0001);
    send(1'b0, 32'h40A00000, 32'h80000000, 32'h40A00000, 4'b0001);
    send(1'b1, 32'hC1200000, 32'hC1200000, 32'h00000000, 4'b0011);
    send(1'b0, 32'h40000000, 32'hC0000000, 32'h00000000, 4'b0011);
    send(1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100);
    send(1'b1, 32'h3F800000, 32'h3F800001, 32'h00000000, 4'b0010);
    send_alu(1'b0, 32'h40000000, 32'h40400000);
    wait_drain();

    // Back-pressure: fill the FIFO behind a stalled result.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_alu(1'b0, 32'h3F800000, 32'h40000000);
    send_alu(1'b1, 32'h40400000, 32'h3F000000);
    send_alu(1'b0, 32'h41000000, 32'h40800000);
    @(negedge clk);
    check_val("in_ready_full", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    check_val("in_ready_still_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) t.push_back(i);
    end
    check_val("burst_count", 32'(t.size()), 32'd3);
    if (t.size() == 3) begin
      check_val("burst_gap0", 32'(t[1] - t[0]), 32'd2);
      check_val("burst_gap1", 32'(t[2] - t[1]), 32'd2);
    end
    wait_drain();

    // Reset while a request executes and another is queued.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send_alu(1'b0, 32'h3F800000, 32'h40000000);
    send_alu(1'b1, 32'h40400000, 32'h3F000000);
    send_alu(1'b0, 32'h41000000, 32'h40800000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check_val("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_rst_idle", 32'(out_valid), 32'd0);
    send(1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1001);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
